// File: rtl/ps2_axi_write_sched.sv
// ps2_axi_write_sched: round-robin scheduler that owns the single AXI4-Lite
// write path for the PS/2 scancode requester (0) and the colour-config
// requester (1). One write in flight at a time; reports completion, slave
// errors and stalls through sticky flags.
module ps2_axi_write_sched #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            REQ0_VALID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ0_DATA,
    output logic                            REQ0_READY,
    input  logic                            REQ1_VALID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ1_DATA,
    output logic                            REQ1_READY,
    output logic                            TXN_DONE,
    output logic                            TXN_ID,
    output logic                            ERROR,
    output logic                            TIMEOUT,
    input  logic                            ERR_CLR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The stall counter is 8 bits wide and saturates, so the threshold is
    // clamped into 1..255.
    localparam int         TO_SAT   = (TIMEOUT_CYCLES > 255) ? 255 :
                                      ((TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES);
    localparam logic [7:0] TO_LIMIT = TO_SAT[7:0];

    state_t     state;
    logic       owner;
    logic       last_grant;
    logic       aw_done;
    logic       w_done;
    logic [7:0] stall_cnt;
    logic [7:0] stall_inc;
    logic       req_any;
    logic       grant_idx;
    logic       aw_hs;
    logic       w_hs;
    logic       in_flight;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;
    assign in_flight = (state == WRITE) || (state == RESP);
    assign stall_inc = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;

    // Round-robin grant, only offered in IDLE; on contention the requester
    // that did not win last time is chosen.
    always_comb begin
        req_any   = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE) begin
            req_any = REQ0_VALID | REQ1_VALID;
            if (REQ0_VALID && REQ1_VALID) begin
                grant_idx = ~last_grant;
            end else begin
                grant_idx = REQ1_VALID;
            end
        end
    end

    assign REQ0_READY = req_any & ~grant_idx;
    assign REQ1_READY = req_any &  grant_idx;

    // Write sequencer: latches the winning request, drives AW/W until each
    // channel handshakes, waits for B and pulses TXN_DONE.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            TXN_DONE      <= 1'b0;
            TXN_ID        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state         <= WRITE;
                        owner         <= grant_idx;
                        last_grant    <= grant_idx;
                        M_AXI_AWADDR  <= grant_idx ? REQ1_ADDR : REQ0_ADDR;
                        M_AXI_WDATA   <= grant_idx ? REQ1_DATA : REQ0_DATA;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                    end
                end
                WRITE: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state        <= RESP;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                RESP: begin
                    if (M_AXI_BVALID) begin
                        state        <= DONE;
                        M_AXI_BREADY <= 1'b0;
                        TXN_DONE     <= 1'b1;
                        TXN_ID       <= owner;
                    end
                end
                DONE: begin
                    TXN_DONE <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall counter and sticky status flags; a set condition overrides a
    // simultaneous ERR_CLR because it is assigned last.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stall_cnt <= 8'd0;
            ERROR     <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            if (req_any) begin
                stall_cnt <= 8'd0;
            end else if (in_flight) begin
                stall_cnt <= stall_inc;
            end
            if (ERR_CLR) begin
                ERROR   <= 1'b0;
                TIMEOUT <= 1'b0;
            end
            if ((state == RESP) && M_AXI_BVALID && (M_AXI_BRESP != 2'b00)) begin
                ERROR <= 1'b1;
            end
            if (in_flight && (stall_inc >= TO_LIMIT)) begin
                TIMEOUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_axi_write_sched.sv
// Scoreboard bench for ps2_axi_write_sched: accepted requests are queued and
// matched against the AW/W handshakes and TXN_DONE pulses; a small slave
// model provides configurable ready delays, response delay and BRESP.
module tb_ps2_axi_write_sched;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        txn_done, txn_id, error, timeout, err_clr;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  bresp;

    ps2_axi_write_sched #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES    (255)
    ) dut (
        .ACLK         (clk),
        .ARESETN      (arst_n),
        .REQ0_VALID   (req0_valid),
        .REQ0_ADDR    (req0_addr),
        .REQ0_DATA    (req0_data),
        .REQ0_READY   (req0_ready),
        .REQ1_VALID   (req1_valid),
        .REQ1_ADDR    (req1_addr),
        .REQ1_DATA    (req1_data),
        .REQ1_READY   (req1_ready),
        .TXN_DONE     (txn_done),
        .TXN_ID       (txn_id),
        .ERROR        (error),
        .TIMEOUT      (timeout),
        .ERR_CLR      (err_clr),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   grant_log[$];
    int   done_cyc_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_count = 0;
    int last_acc_cyc = 0, last_aw_cyc = 0, last_w_cyc = 0, last_b_cyc = 0;
    bit aw_drop_pend = 0, w_drop_pend = 0;

    int       aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0] b_resp = 2'b00;
    int       aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int       base;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model, updated just after each rising edge.
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 1'b0; w_cnt = 0; end
            if (bready) begin
                bvalid = (b_cnt >= b_delay);
                bresp  = bvalid ? b_resp : 2'b00;
                b_cnt++;
            end else begin
                bvalid = 1'b0; bresp = 2'b00; b_cnt = 0;
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (arst_n) begin
            if (aw_drop_pend) begin chk("awvalid_drop", awvalid, 0); aw_drop_pend = 0; end
            if (w_drop_pend)  begin chk("wvalid_drop", wvalid, 0);  w_drop_pend = 0;  end
            if (req0_ready || req1_ready) begin
                chk("ready_onehot", req0_ready & req1_ready, 0);
                mon_e.id   = req1_ready;
                mon_e.addr = req1_ready ? req1_addr : req0_addr;
                mon_e.data = req1_ready ? req1_data : req0_data;
                exp_q.push_back(mon_e);
                grant_log.push_back(int'(req1_ready));
                last_acc_cyc = cyc;
            end
            if (awvalid && awready) begin
                if (exp_q.size() > 0) chk("awaddr", awaddr, exp_q[0].addr);
                else chk("awaddr_qsize", exp_q.size(), 1);
                aw_drop_pend = 1; last_aw_cyc = cyc;
            end
            if (wvalid && wready) begin
                if (exp_q.size() > 0) chk("wdata", wdata, exp_q[0].data);
                else chk("wdata_qsize", exp_q.size(), 1);
                w_drop_pend = 1; last_w_cyc = cyc;
            end
            if (bvalid && bready) last_b_cyc = cyc;
            if (txn_done) begin
                done_count++;
                done_cyc_q.push_back(cyc);
                if (exp_q.size() > 0) begin
                    chk("txn_id", txn_id, exp_q[0].id);
                    void'(exp_q.pop_front());
                end else begin
                    chk("done_qsize", exp_q.size(), 1);
                end
            end
        end else begin
            aw_drop_pend = 0; w_drop_pend = 0;
        end
    end

    task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        @(posedge clk); #1;
        if (id == 0) begin req0_valid = 1; req0_addr = a; req0_data = d; end
        else         begin req1_valid = 1; req1_addr = a; req1_data = d; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin got = 1; break; end
        end
        chk("req_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 1000 && done_count < target; i++) @(negedge clk);
        chk("done_wait", done_count >= target, 1);
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1; err_clr = 1;
        @(posedge clk); #1; err_clr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 0; err_clr = 0;
        req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_txn_done", txn_done, 0);
        chk("rst_txn_id", txn_id, 0);
        chk("rst_error", error, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("awprot", awprot, 0);
        chk("wstrb", wstrb, 4'hF);
        @(posedge clk); #1; arst_n = 1;

        // Single write, zero-wait slave
        base = done_count;
        do_req(0, 32'h10, 32'hA5);
        wait_done(base + 1);
        chk("lat_aw", last_aw_cyc - last_acc_cyc, 1);
        chk("lat_w", last_w_cyc - last_acc_cyc, 1);
        chk("lat_b", last_b_cyc - last_acc_cyc, 2);
        chk("lat_done", done_cyc_q[$] - last_acc_cyc, 3);
        chk("single_error", error, 0);

        // Single requester-1 write, leaves last_grant at 1
        base = done_count;
        do_req(1, 32'h14, 32'h5A);
        wait_done(base + 1);

        // Contention: both held valid for four grants
        grant_log.delete(); done_cyc_q.delete();
        base = done_count;
        @(posedge clk); #1;
        req0_valid = 1; req0_addr = 32'h100; req0_data = 32'h1111_0000;
        req1_valid = 1; req1_addr = 32'h200; req1_data = 32'h2222_0000;
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_done(base + 4);
        chk("grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("grant_order", grant_log[k], k % 2);
        end
        chk("done_count4", done_cyc_q.size(), 4);
        if (done_cyc_q.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("done_spacing", done_cyc_q[k] - done_cyc_q[k-1], 4);
        end

        // Split handshakes: AW late, then W late
        aw_delay = 3; w_delay = 0;
        base = done_count;
        do_req(0, 32'h40, 32'h1234);
        wait_done(base + 1);
        repeat (6) @(negedge clk);
        chk("split1_done_once", done_count, base + 1);
        chk("split1_aw_after_w", last_aw_cyc - last_w_cyc, 3);
        aw_delay = 0; w_delay = 3;
        base = done_count;
        do_req(1, 32'h44, 32'h5678);
        wait_done(base + 1);
        repeat (6) @(negedge clk);
        chk("split2_done_once", done_count, base + 1);
        chk("split2_w_after_aw", last_w_cyc - last_aw_cyc, 3);
        w_delay = 0;

        // Slave error, clear, then set and clear on the same edge
        b_resp = 2'b10;
        base = done_count;
        do_req(1, 32'h20, 32'hC3);
        wait_done(base + 1);
        repeat (2) @(negedge clk);
        chk("error_set", error, 1);
        clr_pulse();
        @(negedge clk);
        chk("error_cleared", error, 0);
        @(posedge clk); #1; err_clr = 1;
        base = done_count;
        do_req(0, 32'h24, 32'h3C);
        begin
            bit seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bvalid && bready) begin seen = 1; break; end
            end
            chk("bresp_seen", seen, 1);
        end
        @(posedge clk); #1; err_clr = 0;
        @(negedge clk);
        chk("error_set_wins", error, 1);
        wait_done(base + 1);
        b_resp = 2'b00;
        clr_pulse();
        @(negedge clk);
        chk("error_cleared2", error, 0);

        // Stall: BVALID withheld past the timeout threshold
        b_delay = 300;
        base = done_count;
        do_req(0, 32'h30, 32'h5A5A);
        for (int i = 0; i <= 260; i++) begin
            @(negedge clk);
            if (i == 254) chk("timeout_before", timeout, 0);
            if (i == 255) chk("timeout_at_255", timeout, 1);
            if (i == 260) chk("bready_stall", bready, 1);
        end
        wait_done(base + 1);
        chk("timeout_sticky", timeout, 1);
        b_delay = 0;
        clr_pulse();
        @(negedge clk);
        chk("timeout_cleared", timeout, 0);

        // Reset while in WRITE
        aw_delay = 6; w_delay = 6;
        base = done_count;
        do_req(0, 32'h50, 32'h77);
        @(posedge clk); #2;
        chk("pre_reset_awvalid", awvalid, 1);
        arst_n = 0;
        #1;
        chk("async_rst_awvalid", awvalid, 0);
        chk("async_rst_wvalid", wvalid, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("no_done_on_reset", done_count, base);
        aw_delay = 0; w_delay = 0;
        @(posedge clk); #1; arst_n = 1;
        do_req(1, 32'h60, 32'hCAFE);
        wait_done(base + 1);
        chk("post_reset_error", error, 0);
        repeat (3) @(negedge clk);
        chk("post_reset_qempty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
